// File: rtl/input_conditioner.sv
// Per-channel two-or-more-stage synchroniser, debounce counter and level/edge outputs.
// Optional edge outputs (rise_o, fall_o, changed_o) compiled in by INPUT_CONDITIONER_EDGE_EN.

module input_conditioner_chan #(
    parameter int   STAGES          = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level
`ifdef INPUT_CONDITIONER_EDGE_EN
    ,
    output logic rise,
    output logic fall,
    output logic flip
`endif
);
    localparam int              CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [STAGES-1:0] chain;
    logic              sync;
    logic [CW-1:0]     cnt;
    logic              take;

    assign sync = chain[STAGES-1];
    // A new level is accepted on the cycle the counter has already seen DEBOUNCE_CYCLES-1 mismatches.
    assign take = (sync != level) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RESET_BIT}};
            cnt   <= '0;
            level <= RESET_BIT;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
            if (sync == level || take)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (take)
                level <= sync;
        end
    end

`ifdef INPUT_CONDITIONER_EDGE_EN
    assign flip = take;

    always_ff @(posedge clk) begin
        if (rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= take & sync;
            fall <= take & ~sync;
        end
    end
`endif
endmodule

module input_conditioner #(
    parameter int                 CHANNELS        = 1,
    parameter int                 STAGES          = 2,
    parameter int                 DEBOUNCE_CYCLES = 4,
    parameter logic [CHANNELS-1:0] RESET_VAL      = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] async_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
    output logic                changed_o
);
`ifdef INPUT_CONDITIONER_EDGE_EN
    logic [CHANNELS-1:0] flip;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        input_conditioner_chan #(
            .STAGES         (STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_BIT      (RESET_VAL[c])
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .async_in(async_i[c]),
            .level   (level_o[c])
`ifdef INPUT_CONDITIONER_EDGE_EN
            ,
            .rise    (rise_o[c]),
            .fall    (fall_o[c]),
            .flip    (flip[c])
`endif
        );
    end

`ifdef INPUT_CONDITIONER_EDGE_EN
    // Built from the same acceptance strobes as rise/fall so it lines up with them.
    always_ff @(posedge clk) begin
        if (rst)
            changed_o <= 1'b0;
        else
            changed_o <= |flip;
    end
`else
    assign rise_o    = '0;
    assign fall_o    = '0;
    assign changed_o = 1'b0;
`endif
endmodule

// File: tb/tb_input_conditioner.sv
// Directed table-driven bench for input_conditioner (4 channels, 2 stages, debounce 4).
// Edge expectations are forced to zero when INPUT_CONDITIONER_EDGE_EN is not defined.

module tb_input_conditioner;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] async_i;
    logic [3:0] level_o, rise_o, fall_o;
    logic       changed_o;

    int checks = 0;
    int errors = 0;

    input_conditioner #(
        .CHANNELS       (4),
        .STAGES         (2),
        .DEBOUNCE_CYCLES(4),
        .RESET_VAL      (4'b0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .async_i  (async_i),
        .level_o  (level_o),
        .rise_o   (rise_o),
        .fall_o   (fall_o),
        .changed_o(changed_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       chg;
    } vec_t;

    vec_t vecs[$];

`ifdef INPUT_CONDITIONER_EDGE_EN
    localparam logic EDGE = 1'b1;
`else
    localparam logic EDGE = 1'b0;
`endif

    task automatic add(input int n, input logic [3:0] a, input logic [3:0] l,
                       input logic [3:0] r, input logic [3:0] f, input logic c);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.a    = a;
            v.lvl  = l;
            v.rise = EDGE ? r : 4'b0000;
            v.fall = EDGE ? f : 4'b0000;
            v.chg  = EDGE ? c : 1'b0;
            vecs.push_back(v);
        end
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @%0d: got %b want %b", name, idx, got, want);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [3:0] l,
                           input logic [3:0] r, input logic [3:0] f, input logic c);
        chk({tag, " level"}, idx, level_o, l);
        chk({tag, " rise"}, idx, rise_o, EDGE ? r : 4'b0000);
        chk({tag, " fall"}, idx, fall_o, EDGE ? f : 4'b0000);
        chk({tag, " changed"}, idx, {3'b000, changed_o}, {3'b000, EDGE ? c : 1'b0});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Row j: async value applied before edge j, outputs expected after edge j.
        add(5, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1);
        add(1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        add(3, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 1'b0);   // 3-cycle glitch on ch1
        add(4, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        add(5, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(5, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(1, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1'b1);
        add(1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0);
        add(5, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b1);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(5, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(1, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 1'b1);
        add(5, 4'b0101, 4'b1010, 4'b0000, 4'b0000, 1'b0);
        add(1, 4'b0101, 4'b0101, 4'b0101, 4'b1010, 1'b1);   // rise and fall on different channels together
        add(1, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0);

        // Reset loads RESET_VAL regardless of the inputs.
        rst     = 1'b1;
        async_i = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("reset", i, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        end

        rst = 1'b0;
        for (int j = 0; j < vecs.size(); j++) begin
            async_i = vecs[j].a;
            tick();
            chk("level", j, level_o, vecs[j].lvl);
            chk("rise", j, rise_o, vecs[j].rise);
            chk("fall", j, fall_o, vecs[j].fall);
            chk("changed", j, {3'b000, changed_o}, {3'b000, vecs[j].chg});
        end

        // Reset from a non-reset level, then abandon a pending ch2 rise mid-debounce.
        rst     = 1'b1;
        async_i = 4'b0000;
        tick();
        chk_all("rst_mid", 0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick();
        rst     = 1'b0;
        async_i = 4'b0100;
        tick();                                   // e0
        tick();                                   // e1
        rst = 1'b1;
        tick();                                   // e2
        chk_all("abandon", 2, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        rst = 1'b0;
        for (int e = 3; e <= 7; e++) begin        // first sampling edge after release is e3
            tick();
            chk_all("resync", e, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        end
        tick();                                   // e8 = e3 + STAGES + DEBOUNCE_CYCLES - 1
        chk_all("resync", 8, 4'b0100, 4'b0100, 4'b0000, 1'b1);
        tick();
        chk_all("resync", 9, 4'b0100, 4'b0000, 4'b0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL provide parameter CHANNELS, default 1: number of independent asynchronous input channels, 1..32.
REQ-002 SHALL provide parameter STAGES, default 2: flip-flop stages in each channel's synchroniser chain, at least 2.
REQ-003 SHALL provide parameter DEBOUNCE_CYCLES, default 4: consecutive synchronised cycles a new level must hold before acceptance, at least 1.
REQ-004 SHALL provide parameter RESET_VAL, default all zeros, CHANNELS bits wide: per-channel reset level.
REQ-005 SHALL provide port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-006 SHALL provide port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL provide port async_i, input, CHANNELS bits: asynchronous raw inputs, one bit per channel.
REQ-008 SHALL provide port level_o, output, CHANNELS bits: registered, debounced, synchronised level per channel.
REQ-009 SHALL provide port rise_o, output, CHANNELS bits: one-cycle pulse when the corresponding level_o bit goes 0 to 1.
REQ-010 SHALL provide port fall_o, output, CHANNELS bits: one-cycle pulse when the corresponding level_o bit goes 1 to 0.
REQ-011 SHALL provide port changed_o, output, 1 bit: registered OR of all rise_o and fall_o bits, asserted in the same cycle as those pulses.

Function
REQ-012 Each channel SHALL pass async_i[c] through a STAGES-deep flip-flop chain; sync[c] is the last stage of that chain.
REQ-013 Each channel SHALL own a counter of width clog2(DEBOUNCE_CYCLES+1); channels SHALL be fully independent.
REQ-014 Per clock, when sync[c] == level_o[c]: the counter SHALL clear to 0 and level_o[c] SHALL hold.
REQ-015 Per clock, when sync[c] != level_o[c] and the counter < DEBOUNCE_CYCLES-1: the counter SHALL increment by 1.
REQ-016 Per clock, when sync[c] != level_o[c] and the counter == DEBOUNCE_CYCLES-1: level_o[c] SHALL take sync[c], the counter SHALL clear, and rise_o[c] or fall_o[c] SHALL assert for exactly that one cycle.
REQ-017 Latency: a stable change on async_i[c] sampled at edge k SHALL appear on level_o[c] at edge k+STAGES+DEBOUNCE_CYCLES-1.
REQ-018 Any sync[c] pulse shorter than DEBOUNCE_CYCLES cycles SHALL be rejected: level_o unchanged, no rise/fall pulse, counter cleared when the pulse ends.
REQ-019 DEBOUNCE_CYCLES=1 SHALL reduce the block to a synchroniser plus one register and edge detector.
REQ-020 rise_o[c] and fall_o[c] SHALL never be asserted together; a channel SHALL not pulse on consecutive cycles unless DEBOUNCE_CYCLES=1.
REQ-021 The counter SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap-around).
REQ-022 Simultaneous transitions on several channels SHALL produce simultaneous pulses; changed_o SHALL assert once, for one cycle.

Reset
REQ-023 While rst=1, every synchroniser stage and level_o SHALL load RESET_VAL, all counters SHALL clear to 0, and rise_o, fall_o and changed_o SHALL be 0.
REQ-024 The first cycle after rst deasserts SHALL produce no pulse if async_i equals RESET_VAL.
REQ-025 rst asserted mid-debounce SHALL abandon the pending transition without a pulse.

Configuration
REQ-026 Macro INPUT_CONDITIONER_EDGE_EN, when defined, SHALL compile in the rise_o, fall_o and changed_o logic as specified above.
REQ-027 When INPUT_CONDITIONER_EDGE_EN is undefined, rise_o, fall_o and changed_o SHALL be constant 0, their registers SHALL be absent, and level_o behaviour SHALL be unchanged.

Verification
All scenarios use CHANNELS=4, STAGES=2, DEBOUNCE_CYCLES=4, RESET_VAL=4'b0000, with INPUT_CONDITIONER_EDGE_EN defined unless noted.
REQ-028 After reset release, set async_i=4'b0001 at edge k -> level_o=4'b0001 at edge k+5; rise_o=4'b0001 and changed_o=1 for that cycle only.
REQ-029 Drive async_i[1] high for 3 cycles, then low -> level_o[1] stays 0; rise_o and changed_o stay 0 throughout.
REQ-030 Set async_i=4'b1111 at one edge, then async_i=4'b0000 after level_o has settled -> level_o=4'b1111, then rise_o=4'b1111 for one cycle; later fall_o=4'b1111 for one cycle; changed_o high once per event.
REQ-031 Assert rst 2 cycles after async_i[2] rises, deassert 1 cycle later, keep async_i[2]=1 -> no pulse during reset; level_o[2]=1 exactly STAGES+DEBOUNCE_CYCLES-1 edges after the first sampling edge following reset release.
REQ-032 Rebuild with INPUT_CONDITIONER_EDGE_EN undefined and repeat REQ-028 -> level_o timing identical; rise_o, fall_o and changed_o stay 0 throughout.
